// File: rtl/frec_divider_prog_if.sv
// Control/status bundle for the programmable divider: enable, sync, divisor load in; tick, toggle, count, status out.
// With FREC_DIVIDER_PROG_DUTY_EN defined the bundle also carries the duty request and the PWM output.
interface frec_divider_prog_if #(
  parameter int WIDTH = 26
);
  logic             iEnable;
  logic             iSync;
  logic             iLoad;
  logic [WIDTH-1:0] iDiv;
  logic             oTick;
  logic             oToggle;
  logic [WIDTH-1:0] oCount;
  logic             oBusy;
  logic             oErr;
`ifdef FREC_DIVIDER_PROG_DUTY_EN
  logic [WIDTH-1:0] iDuty;
  logic             oPwm;

  modport master (
    output iEnable, iSync, iLoad, iDiv, iDuty,
    input  oTick, oToggle, oCount, oBusy, oErr, oPwm
  );
  modport slave (
    input  iEnable, iSync, iLoad, iDiv, iDuty,
    output oTick, oToggle, oCount, oBusy, oErr, oPwm
  );
`else
  modport master (
    output iEnable, iSync, iLoad, iDiv,
    input  oTick, oToggle, oCount, oBusy, oErr
  );
  modport slave (
    input  iEnable, iSync, iLoad, iDiv,
    output oTick, oToggle, oCount, oBusy, oErr
  );
`endif
endinterface

// File: rtl/frec_divider_prog.sv
// Runtime-programmable clock divider: tick every DIV clocks, 50% toggle, live count; divisor swaps only at a period boundary.
// Optional duty-cycle PWM output is built when FREC_DIVIDER_PROG_DUTY_EN is defined.
module frec_divider_prog #(
  parameter int          WIDTH       = 26,
  parameter int unsigned DEFAULT_DIV = 25_000_000
) (
  input logic               iClk,
  input logic               iRst,
  frec_divider_prog_if.slave bus
);
  localparam logic [WIDTH-1:0] C_DEFAULT_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] C_ONE         = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_pend_div;
  logic             r_tick;
  logic             r_toggle;
  logic             r_busy;
  logic             r_err;

  logic             w_wrap;
  logic             w_apply;
  logic             w_load_ok;
  logic [WIDTH-1:0] w_next_count;
  logic [WIDTH-1:0] w_next_div;

  // r_div is never zero, so DIV-1 cannot underflow and the wrap is an equality compare.
  assign w_wrap    = (r_count == r_div - C_ONE);
  assign w_load_ok = bus.iLoad && (bus.iDiv != '0);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_count = r_count;
    w_apply      = 1'b0;
    if (bus.iSync) begin
      w_next_count = '0;
      w_apply      = r_busy;
    end else if (bus.iEnable) begin
      if (w_wrap) begin
        w_next_count = '0;
        w_apply      = r_busy;
      end else begin
        w_next_count = r_count + C_ONE;
      end
    end
  end

  assign w_next_div = w_apply ? r_pend_div : r_div;

  // NOTE: state registers use non-blocking assignments; reset is synchronous, sampled on the clock edge.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_count    <= '0;
      r_div      <= C_DEFAULT_DIV;
      r_pend_div <= '0;
      r_tick     <= 1'b0;
      r_toggle   <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_div   <= w_next_div;
      if (bus.iSync) begin
        r_tick   <= 1'b0;
        r_toggle <= 1'b0;
      end else if (bus.iEnable) begin
        r_tick <= w_wrap;
        if (w_wrap) r_toggle <= ~r_toggle;
      end else begin
        r_tick <= 1'b0;
      end
      // A load on the apply edge wins: the old pending goes live, the new one stays pending.
      if (w_load_ok) begin
        r_pend_div <= bus.iDiv;
        r_busy     <= 1'b1;
      end else if (w_apply) begin
        r_busy <= 1'b0;
      end
      r_err <= bus.iLoad && (bus.iDiv == '0);
    end
  end

  assign bus.oTick   = r_tick;
  assign bus.oToggle = r_toggle;
  assign bus.oCount  = r_count;
  assign bus.oBusy   = r_busy;
  assign bus.oErr    = r_err;

`ifdef FREC_DIVIDER_PROG_DUTY_EN
  localparam logic [WIDTH-1:0] C_DEFAULT_DUTY = WIDTH'(DEFAULT_DIV / 2);

  logic [WIDTH-1:0] r_duty;
  logic [WIDTH-1:0] r_pend_duty;
  logic             r_pwm;
  logic [WIDTH-1:0] w_next_duty;

  assign w_next_duty = w_apply ? r_pend_duty : r_duty;

  // PWM compares against the count and duty that are live after this edge, so it stays aligned with oCount.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_duty      <= C_DEFAULT_DUTY;
      r_pend_duty <= '0;
      r_pwm       <= 1'b0;
    end else begin
      r_duty <= w_next_duty;
      if (w_load_ok) r_pend_duty <= bus.iDuty;
      if (bus.iSync || bus.iEnable) r_pwm <= (w_next_count < w_next_duty);
    end
  end

  assign bus.oPwm = r_pwm;
`endif

endmodule

// File: tb/tb_frec_divider_prog.sv
// Self-checking bench for frec_divider_prog (WIDTH=8, DEFAULT_DIV=5): vector table, hand corner sequences, random vs model.
module tb_frec_divider_prog;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frec_divider_prog_if #(.WIDTH(WIDTH)) bus ();

  frec_divider_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(5)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_model = 1'b0;

  // Behavioural reference: modulo counter, tick = "count came back to 0".
  int m_count, m_tog, m_tick, m_busy, m_err, m_div, m_pend;
  int m_duty, m_pduty, m_pwm;

  function automatic void model_step(input bit r, input bit en, input bit sync, input bit load,
                                     input int div_in, input int duty_in);
    bit apply;
    if (r) begin
      m_count = 0; m_tog = 0; m_tick = 0; m_busy = 0; m_err = 0;
      m_div = 5; m_pend = 0; m_duty = 2; m_pduty = 0; m_pwm = 0;
      return;
    end
    apply = 1'b0;
    if (sync) begin
      m_count = 0; m_tog = 0; m_tick = 0;
      apply = (m_busy != 0);
    end else if (en) begin
      m_count = (m_count + 1) % m_div;
      m_tick  = (m_count == 0) ? 1 : 0;
      if (m_tick != 0) begin
        m_tog = 1 - m_tog;
        apply = (m_busy != 0);
      end
    end else begin
      m_tick = 0;
    end
    if (apply) begin
      m_div = m_pend; m_duty = m_pduty; m_busy = 0;
    end
    m_err = (load && div_in == 0) ? 1 : 0;
    if (load && div_in != 0) begin
      m_pend = div_in; m_pduty = duty_in; m_busy = 1;
    end
    if (sync || en) m_pwm = (m_count < m_duty) ? 1 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input int tick, input int tog, input int cnt,
                            input int busy, input int err);
    check({tag, " tick"},   32'(bus.oTick),   32'(tick));
    check({tag, " toggle"}, 32'(bus.oToggle), 32'(tog));
    check({tag, " count"},  32'(bus.oCount),  32'(cnt));
    check({tag, " busy"},   32'(bus.oBusy),   32'(busy));
    check({tag, " err"},    32'(bus.oErr),    32'(err));
  endtask

  task automatic step(input bit r, input bit en, input bit sync, input bit load,
                      input int div_in, input int duty_in);
    rst         = r;
    bus.iEnable = en;
    bus.iSync   = sync;
    bus.iLoad   = load;
    bus.iDiv    = WIDTH'(div_in);
`ifdef FREC_DIVIDER_PROG_DUTY_EN
    bus.iDuty   = WIDTH'(duty_in);
`endif
    @(posedge clk);
    #1;
    model_step(r, en, sync, load, div_in, duty_in);
    if (chk_model) begin
      check("rnd tick",   32'(bus.oTick),   32'(m_tick));
      check("rnd toggle", 32'(bus.oToggle), 32'(m_tog));
      check("rnd count",  32'(bus.oCount),  32'(m_count));
      check("rnd busy",   32'(bus.oBusy),   32'(m_busy));
      check("rnd err",    32'(bus.oErr),    32'(m_err));
`ifdef FREC_DIVIDER_PROG_DUTY_EN
      check("rnd pwm",    32'(bus.oPwm),    32'(m_pwm));
`endif
    end
  endtask

  typedef struct {
    bit en; bit sync; bit load; int div;
    int tick; int tog; int cnt; int busy; int err;
  } vec_t;

  function automatic vec_t mk(input bit en, input bit sync, input bit load, input int div,
                              input int tick, input int tog, input int cnt, input int busy, input int err);
    vec_t v;
    v.en = en; v.sync = sync; v.load = load; v.div = div;
    v.tick = tick; v.tog = tog; v.cnt = cnt; v.busy = busy; v.err = err;
    return v;
  endfunction

  vec_t vecs[21];

  initial begin
    vecs[0]  = mk(1,0,0,0, 0,0,1,0,0);
    vecs[1]  = mk(1,0,0,0, 0,0,2,0,0);
    vecs[2]  = mk(1,0,0,0, 0,0,3,0,0);
    vecs[3]  = mk(1,0,0,0, 0,0,4,0,0);
    vecs[4]  = mk(1,0,0,0, 1,1,0,0,0);
    vecs[5]  = mk(1,0,1,0, 0,1,1,0,1);
    vecs[6]  = mk(1,0,0,0, 0,1,2,0,0);
    vecs[7]  = mk(1,0,1,3, 0,1,3,1,0);
    vecs[8]  = mk(1,0,0,0, 0,1,4,1,0);
    vecs[9]  = mk(1,0,0,0, 1,0,0,0,0);
    vecs[10] = mk(1,0,0,0, 0,0,1,0,0);
    vecs[11] = mk(1,0,0,0, 0,0,2,0,0);
    vecs[12] = mk(1,0,0,0, 1,1,0,0,0);
    vecs[13] = mk(0,0,0,0, 0,1,0,0,0);
    vecs[14] = mk(0,0,0,0, 0,1,0,0,0);
    vecs[15] = mk(1,1,0,0, 0,0,0,0,0);
    vecs[16] = mk(1,0,0,0, 0,0,1,0,0);
    vecs[17] = mk(1,0,1,2, 0,0,2,1,0);
    vecs[18] = mk(1,0,0,0, 1,1,0,0,0);
    vecs[19] = mk(1,0,0,0, 0,1,1,0,0);
    vecs[20] = mk(1,0,0,0, 1,0,0,0,0);

    // Reset state
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    expect_out("reset", 0, 0, 0, 0, 0);

    // Vector table: DIV 5 run, rejected load, load 3, freeze, sync, load 2
    for (int i = 0; i < 21; i++) begin
      step(0, vecs[i].en, vecs[i].sync, vecs[i].load, vecs[i].div, 0);
      expect_out($sformatf("vec%0d", i), vecs[i].tick, vecs[i].tog, vecs[i].cnt, vecs[i].busy, vecs[i].err);
    end

    // Freeze at count 3, then load 2 landing on the count-4 cycle
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    expect_out("pre-freeze", 0, 0, 3, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 0, 0, 0, 0);
      check("freeze count", 32'(bus.oCount), 32'd3);
      check("freeze tick",  32'(bus.oTick),  32'd0);
    end
    step(0, 1, 0, 1, 2, 0);  expect_out("reen1", 0, 0, 4, 1, 0);
    step(0, 1, 0, 0, 0, 0);  expect_out("reen2", 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);  expect_out("div2a", 0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0);  expect_out("div2b", 1, 0, 0, 0, 0);

    // Load on the wrap edge: old DIV runs one more period
    step(0, 1, 0, 0, 0, 0);  expect_out("wrapld0", 0, 0, 1, 0, 0);
    step(0, 1, 0, 1, 3, 0);  expect_out("wrapld1", 1, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0);  expect_out("wrapld2", 0, 1, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0);  expect_out("wrapld3", 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);  expect_out("wrapld4", 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0);  expect_out("wrapld5", 0, 0, 2, 0, 0);
    step(0, 1, 0, 0, 0, 0);  expect_out("wrapld6", 1, 1, 0, 0, 0);

    // Reset mid-period
    step(0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);  expect_out("midrst", 0, 0, 0, 0, 0);

    // DIV=1 applied through sync
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0);
    step(0, 1, 1, 0, 0, 0);  expect_out("div1 sync", 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);  expect_out("div1 a", 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);  expect_out("div1 b", 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);  expect_out("div1 c", 1, 1, 0, 0, 0);

`ifdef FREC_DIVIDER_PROG_DUTY_EN
    begin
      int highs;
      step(0, 1, 0, 1, 5, 2);
      step(0, 1, 1, 0, 0, 0);
      highs = 0;
      for (int i = 0; i < 10; i++) begin
        step(0, 1, 0, 0, 0, 0);
        highs += int'(bus.oPwm);
      end
      check("pwm duty2 highs", 32'(highs), 32'd4);
      step(0, 1, 0, 1, 5, 7);
      step(0, 1, 1, 0, 0, 0);
      highs = 0;
      for (int i = 0; i < 5; i++) begin
        step(0, 1, 0, 0, 0, 0);
        highs += int'(bus.oPwm);
      end
      check("pwm duty7 highs", 32'(highs), 32'd5);
    end
`endif

    // Randomized run against the reference model
    step(1, 0, 0, 0, 0, 0);
    chk_model = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 9)),
           int'($urandom_range(0, 9)));
    end
    chk_model = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
